// File: rtl/shift_sequencer.sv
// Multi-cycle variable-amount shifter (SLL/SRL/SRA/ROTR) for the execute stage.
// Each cycle applies either a coarse STEP-bit shift or a 1-bit shift until the count is exhausted.
module shift_sequencer #(
    parameter int SIZE    = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               flush,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [SIZE-1:0]    a,
    output logic [SIZE-1:0]    result,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROTR} op_t;

    localparam logic [SHAMT_W-1:0] STEP_CNT = SHAMT_W'(STEP);
    localparam logic [SHAMT_W-1:0] ONE_CNT  = SHAMT_W'(1);

    state_t             state;
    op_t                op_q;
    logic [SIZE-1:0]    acc;
    logic [SHAMT_W-1:0] cnt;

    logic               coarse;
    logic [SIZE-1:0]    acc_step;
    logic [SHAMT_W-1:0] cnt_step;

    // One fixed-distance stage; only two distances exist, so no barrel shifter is built.
    function automatic logic [SIZE-1:0] shift_stage(input logic [SIZE-1:0] v, input op_t o,
                                                    input logic big);
        logic [SIZE-1:0] r;
        r = v;
        case (o)
            OP_SLL:  r = big ? (v << STEP) : (v << 1);
            OP_SRL:  r = big ? (v >> STEP) : (v >> 1);
            OP_SRA:  r = big ? SIZE'($signed(v) >>> STEP) : SIZE'($signed(v) >>> 1);
            OP_ROTR: r = big ? {v[STEP-1:0], v[SIZE-1:STEP]} : {v[0], v[SIZE-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        coarse   = 1'b0;
        acc_step = acc;
        cnt_step = cnt;
        coarse   = (cnt >= STEP_CNT);
        acc_step = shift_stage(acc, op_q, coarse);
        cnt_step = coarse ? (cnt - STEP_CNT) : (cnt - ONE_CNT);
    end

    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset too, so result reads 0 out of reset.
        if (rst) begin
            state  <= IDLE;
            op_q   <= OP_SLL;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc  <= a;
                        cnt  <= shamt;
                        op_q <= op_t'(op);
                        busy <= 1'b1;
                        if (shamt == '0) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= a;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_step;
                    cnt <= cnt_step;
                    // result is loaded on the way into DONE so it is valid with the done pulse
                    if (cnt_step == '0) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= acc_step;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
